cache_ctrl_fsm: RTL and testbench

Control state machine for the 2-way set-associative data cache. Resolves CPU hit/miss and drives the per-way data write controls (way select, line load, data source) that the data-line write-mask stage consumes. Also sequences dirty-victim writeback and line fill over the physical memory port, and maintains valid, dirty and LRU metadata. Sits between the CPU request interface / tag-compare datapath and the data/tag/metadata arrays.

---
 rtl/cache_ctrl_fsm.sv | 173 +++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// Control FSM for a 2-way set-associative cache: hit resolution, writeback/fill sequencing, metadata writes.
// Optional saturating performance counters are built only when CACHE_PERF_CNT_EN is defined.
package waymux;
  typedef enum logic {way0 = 1'b0, way1 = 1'b1} waymux_sel_t;
endpackage

package datamux;
  typedef enum logic {cache = 1'b0, cpu_be = 1'b1} datamux_sel_t;
endpackage

module cache_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  hit0,
  input  logic                  hit1,
  input  logic                  valid0,
  input  logic                  valid1,
  input  logic                  dirty0,
  input  logic                  dirty1,
  input  logic                  lru,
  input  logic                  pmem_resp,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output waymux::waymux_sel_t   way_sel,
  output logic                  data_ld,
  output datamux::datamux_sel_t data_src,
  output logic                  tag_ld,
  output logic                  valid_ld,
  output logic                  dirty_ld,
  output logic                  lru_ld,
  output logic                  dirty_in,
  output logic                  lru_in,
  output logic                  paddr_sel,
  output logic                  proto_err
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt,
  output logic [CNT_W-1:0]      wb_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t state_q, state_d;
  logic   victim_q, victim_d;
  logic   proto_err_q;
  logic   req, hit, victim_dirty;

  assign req          = mem_read | mem_write;
  assign hit          = hit0 | hit1;
  assign victim_dirty = lru ? (valid1 & dirty1) : (valid0 & dirty0);
  assign proto_err    = proto_err_q;

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    way_sel    = waymux::way0;
    data_ld    = 1'b0;
    data_src   = datamux::cache;
    tag_ld     = 1'b0;
    valid_ld   = 1'b0;
    dirty_ld   = 1'b0;
    lru_ld     = 1'b0;
    dirty_in   = 1'b0;
    lru_in     = 1'b0;
    paddr_sel  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          lru_ld   = 1'b1;
          // hit0 wins when both ways claim the line; the other way becomes LRU
          lru_in   = hit0;
          if (mem_write) begin
            way_sel  = hit0 ? waymux::way0 : waymux::way1;
            data_ld  = 1'b1;
            data_src = datamux::cpu_be;
            dirty_ld = 1'b1;
            dirty_in = 1'b1;
          end
        end else if (req) begin
          victim_d = lru;
          state_d  = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        paddr_sel  = 1'b1;
        way_sel    = waymux::waymux_sel_t'(victim_q);
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        way_sel   = waymux::waymux_sel_t'(victim_q);
        if (pmem_resp) begin
          data_ld  = 1'b1;
          tag_ld   = 1'b1;
          valid_ld = 1'b1;
          dirty_ld = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs must fall the instant reset asserts, not at the next edge.
    if (!rst_n) begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      way_sel    = waymux::way0;
      data_ld    = 1'b0;
      data_src   = datamux::cache;
      tag_ld     = 1'b0;
      valid_ld   = 1'b0;
      dirty_ld   = 1'b0;
      lru_ld     = 1'b0;
      dirty_in   = 1'b0;
      lru_in     = 1'b0;
      paddr_sel  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      victim_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (state_q == IDLE && req && hit0 && hit1) proto_err_q <= 1'b1;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic             hit_ev, miss_ev, wb_ev;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  assign hit_ev  = (state_q == IDLE) && req && hit;
  assign miss_ev = (state_q == IDLE) && req && !hit;
  assign wb_ev   = (state_q == WRITEBACK) && pmem_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (hit_ev  && !(&hit_cnt_q))  hit_cnt_q  <= hit_cnt_q  + CNT_W'(1);
      if (miss_ev && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      if (wb_ev   && !(&wb_cnt_q))   wb_cnt_q   <= wb_cnt_q   + CNT_W'(1);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be positive");
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Scoreboard bench for cache_ctrl_fsm: directed stimulus queues expected output snapshots,
// a negedge monitor compares them on every completion / memory-start event.
module tb_cache_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read = 0, mem_write = 0, hit0 = 0, hit1 = 0;
  logic valid0 = 0, valid1 = 0, dirty0 = 0, dirty1 = 0, lru = 0, pmem_resp = 0;
  logic mem_resp, pmem_read, pmem_write, data_ld, tag_ld, valid_ld, dirty_ld;
  logic lru_ld, dirty_in, lru_in, paddr_sel, proto_err;
  waymux::waymux_sel_t   way_sel;
  datamux::datamux_sel_t data_src;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  cache_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
    .dirty0(dirty0), .dirty1(dirty1), .lru(lru), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .way_sel(way_sel), .data_ld(data_ld), .data_src(data_src), .tag_ld(tag_ld),
    .valid_ld(valid_ld), .dirty_ld(dirty_ld), .lru_ld(lru_ld), .dirty_in(dirty_in),
    .lru_in(lru_in), .paddr_sel(paddr_sel), .proto_err(proto_err)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [12:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_pr = 1'b0, prev_pw = 1'b0;

  // Snapshot bit order: resp,prd,pwr,way,dld,dsrc,tag,val,dirld,lruld,dirin,lruin,psel
  function automatic logic [12:0] snap();
    return {mem_resp, pmem_read, pmem_write, logic'(way_sel), data_ld, logic'(data_src),
            tag_ld, valid_ld, dirty_ld, lru_ld, dirty_in, lru_in, paddr_sel};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else begin
      $display("txn %s ok value=%0h", name, got);
    end
  endtask

  task automatic push(input string name, input logic [12:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an event is a CPU response, a data write, or the start of a memory strobe.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (mem_resp || data_ld || (pmem_read && !prev_pr) || (pmem_write && !prev_pw))) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {19'd0, snap()}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check(e.name, {19'd0, snap()}, {19'd0, e.v});
      end
    end
    prev_pr = pmem_read;
    prev_pw = pmem_write;
  end

  initial begin
    repeat (3) tick();
    check("reset_outputs", {19'd0, snap()}, 32'h0);
    check("reset_proto_err", {31'd0, proto_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: read hit way1 -> resp, lru points to way0
    push("t1_read_hit1", 13'b1_0_0_0_0_0_0_0_0_1_0_0_0);
    mem_read = 1; hit1 = 1; lru = 1;
    tick();
    mem_read = 0; hit1 = 0; lru = 0;
    tick();

    // 2: write hit way0
    push("t2_write_hit0", 13'b1_0_0_0_1_1_0_0_1_1_1_1_0);
    mem_write = 1; hit0 = 1;
    tick();
    mem_write = 0; hit0 = 0;
    tick();

    // stray pmem_resp in IDLE must produce nothing
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    tick();

    // 3: read miss, clean victim way1, lru wiggles mid-miss
    push("t3_fill_start", 13'b0_1_0_1_0_0_0_0_0_0_0_0_0);
    push("t3_fill_done",  13'b0_1_0_1_1_0_1_1_1_0_0_0_0);
    push("t3_hit_after",  13'b1_0_0_0_0_0_0_0_0_1_0_0_0);
    mem_read = 1; lru = 1; valid1 = 0;
    tick();
    lru = 0;
    repeat (4) tick();
    pmem_resp = 1;
    tick();
    pmem_resp = 0; hit1 = 1; lru = 1;
    tick();
    mem_read = 0; hit1 = 0; lru = 0;
    tick();

    // 4: write miss, dirty victim way0 -> writeback then fill then write hit
    push("t4_wb_start",   13'b0_0_1_0_0_0_0_0_0_0_0_0_1);
    push("t4_fill_start", 13'b0_1_0_0_0_0_0_0_0_0_0_0_0);
    push("t4_fill_done",  13'b0_1_0_0_1_0_1_1_1_0_0_0_0);
    push("t4_write_hit",  13'b1_0_0_0_1_1_0_0_1_1_1_1_0);
    mem_write = 1; lru = 0; valid0 = 1; dirty0 = 1;
    tick();
    lru = 1;
    repeat (2) tick();
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    repeat (2) tick();
    pmem_resp = 1;
    tick();
    pmem_resp = 0; hit0 = 1;
    tick();
    mem_write = 0; hit0 = 0; lru = 0; valid0 = 0; dirty0 = 0;
    tick();

`ifdef CACHE_PERF_CNT_EN
    check("hit_cnt",  hit_cnt,  32'd4);
    check("miss_cnt", miss_cnt, 32'd2);
    check("wb_cnt",   wb_cnt,   32'd1);
`endif

    // 5: async reset mid-fill
    push("t5_fill_start", 13'b0_1_0_1_0_0_0_0_0_0_0_0_0);
    mem_read = 1; lru = 1; valid1 = 0;
    repeat (3) tick();
    check("t5_pmem_read_before_rst", {31'd0, pmem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_outputs_in_rst", {19'd0, snap()}, 32'h0);
    mem_read = 0; lru = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("t5_after_release", {19'd0, snap()}, 32'h0);
`ifdef CACHE_PERF_CNT_EN
    check("t5_hit_cnt_cleared", hit_cnt, 32'd0);
`endif

    // 6: both ways hit -> way0 wins, proto_err sticky until reset
    push("t6_double_hit", 13'b1_0_0_0_0_0_0_0_0_1_0_1_0);
    mem_read = 1; hit0 = 1; hit1 = 1; lru = 0;
    tick();
    check("t6_proto_err_set", {31'd0, proto_err}, 32'd1);
    mem_read = 0; hit0 = 0; hit1 = 0;
    repeat (3) tick();
    check("t6_proto_err_sticky", {31'd0, proto_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_proto_err_cleared", {31'd0, proto_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
